// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - 32-bit MEM-stage access split into two 16-bit SRAM transfers (optional SRAM_ACCESS_CNT_EN access counters)
`timescale 1ns/1ps
module sram_mem_controller #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
`ifdef SRAM_ACCESS_CNT_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        is_wr_q, is_wr_d;
   logic [16:0] offset_q, offset_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] rdlo_q, rdlo_d;
   logic [31:0] rdata_q, rdata_d;
   logic [18:0] off19;
   logic        phase_end;
   logic        unused_bits;

   // Only offset bits [18:2] reach the SRAM, so a 19-bit subtraction gives the same wrap/alias behaviour.
   assign off19       = {address[18:2], 2'b00} - BASE_ADDR[18:0];
   assign unused_bits = ^{address[31:19], address[1:0], off19[1:0]};
   assign phase_end   = (cnt_q == LAST);
   assign read_data   = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         is_wr_q  <= 1'b0;
         offset_q <= 17'd0;
         wdata_q  <= 32'd0;
         rdlo_q   <= 16'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         offset_q <= offset_d;
         wdata_q  <= wdata_d;
         rdlo_q   <= rdlo_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_wr_d     = is_wr_q;
      offset_d    = offset_q;
      wdata_d     = wdata_q;
      rdlo_d      = rdlo_q;
      rdata_d     = rdata_q;
      ready       = 1'b0;
      sram_addr   = 18'd0;
      sram_dq_out = 16'd0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state_q)
         IDLE: begin
            ready = !rd_en && !wr_en;
            if (rd_en || wr_en) begin
               is_wr_d  = wr_en;
               offset_d = off19[18:2];
               wdata_d  = write_data;
               cnt_d    = 4'd0;
               state_d  = LOW;
            end
         end
         LOW: begin
            sram_addr = {offset_q, 1'b0};
            if (is_wr_q) begin
               sram_dq_out = wdata_q[15:0];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end else if (phase_end) begin
               rdlo_d = sram_dq_in;
            end
            if (phase_end) begin
               cnt_d   = 4'd0;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HIGH: begin
            sram_addr = {offset_q, 1'b1};
            if (is_wr_q) begin
               sram_dq_out = wdata_q[31:16];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end else if (phase_end) begin
               // Publish the whole word at once so read_data never shows a half-updated value.
               rdata_d = {sram_dq_in, rdlo_q};
            end
            if (phase_end) begin
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SRAM_ACCESS_CNT_EN
   logic [15:0] rd_count_q, wr_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else if (state_q == DONE) begin
         if (is_wr_q) begin
            if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
         end else begin
            if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - self-checking bench for sram_mem_controller
`timescale 1ns/1ps
module tb_sram_mem_controller;
   localparam logic [31:0] BASE = 32'd1024;
   localparam int          WC   = 2;

   logic        clk = 1'b0;
   logic        rst, rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready, sram_dq_oe, sram_we_n;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
`ifdef SRAM_ACCESS_CNT_EN
   logic [15:0] rd_count, wr_count;
`endif

   int tests = 0;
   int fails = 0;

   bit [15:0] mem     [0:262143];
   bit [15:0] ref_mem [0:262143];
   logic [31:0] cur_rd;

   sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_ACCESS_CNT_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   // External SRAM: write on clock edge while strobed, asynchronous read.
   always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
   assign sram_dq_in = mem[sram_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] hw_of(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) & 32'h0007_FFFC;
      return off[18:1];
   endfunction

   task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
      logic [17:0] h;
      h = hw_of(a);
      @(negedge clk);
      rd_en = r; wr_en = w; address = a; write_data = wd;
      #1;
      chk("ready_req_cycle", {31'd0, ready}, 32'd0);
      for (int c = 1; c <= 2 * WC; c++) begin
         @(negedge clk);
         if (c == 1) begin
            rd_en = 1'b0; wr_en = 1'b0;
            address = $urandom; write_data = $urandom;
         end
         #1;
         chk("ready_busy", {31'd0, ready}, 32'd0);
         chk("sram_addr", {14'd0, sram_addr}, {14'd0, h + ((c > WC) ? 18'd1 : 18'd0)});
         chk("we_n", {31'd0, sram_we_n}, {31'd0, !w});
         chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, w});
         if (w) chk("dq_out", {16'd0, sram_dq_out}, {16'd0, (c > WC) ? wd[31:16] : wd[15:0]});
      end
      @(negedge clk);
      #1;
      chk("ready_done", {31'd0, ready}, 32'd1);
      chk("we_n_done", {31'd0, sram_we_n}, 32'd1);
      chk("read_data", read_data, exp_rd);
      if (w) begin
         ref_mem[h]     = wd[15:0];
         ref_mem[h + 1] = wd[31:16];
      end
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [17:0] h;
      int pulses;
      vecs[0] = '{1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'd1028,   32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'd1032,   32'h12345678, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b0, 32'd1032,   32'h0,        32'h12345678};
      vecs[4] = '{1'b0, 1'b1, 32'd1020,   32'hA5A55A5A, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'hA5A55A5A};
      vecs[6] = '{1'b0, 1'b1, 32'd1024,   32'hCAFEF00D, 32'hA5A55A5A};
      vecs[7] = '{1'b1, 1'b0, 32'd525312, 32'h0,        32'hCAFEF00D};

      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
      rst = 1'b0;
      cur_rd = 32'd0;

      for (int i = 0; i < 8; i++) begin
         do_access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_rd);
         cur_rd = vecs[i].exp_rd;
      end

      for (int i = 0; i < 40; i++) begin
         logic r, w;
         logic [31:0] a, wd, e;
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1'b1;
         if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 8));
         else                           a = BASE + 32'(4 * $urandom_range(0, 63));
         a  = a | 32'($urandom_range(0, 3));
         wd = $urandom;
         h  = hw_of(a);
         e  = w ? cur_rd : {ref_mem[h + 1], ref_mem[h]};
         do_access(r, w, a, wd, e);
         cur_rd = e;
      end

      // Back-to-back loads with rd_en held high: two separate accesses.
      @(negedge clk);
      rd_en = 1'b1; address = 32'd1024;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 6) address = 32'd1032;
         #1;
         if (ready) pulses++;
         chk("b2b_ready", {31'd0, ready}, {31'd0, (c == 5 || c == 11)});
         if (c == 7 || c == 8)  chk("b2b_addr_lo", {14'd0, sram_addr}, 32'd4);
         if (c == 9 || c == 10) chk("b2b_addr_hi", {14'd0, sram_addr}, 32'd5);
         if (c == 5)  chk("b2b_data0", read_data, {ref_mem[1], ref_mem[0]});
         if (c == 11) chk("b2b_data1", read_data, {ref_mem[5], ref_mem[4]});
      end
      rd_en = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);
      cur_rd = {ref_mem[5], ref_mem[4]};

      // Reset during the HIGH phase of a store.
      h = hw_of(32'd1036);
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1036; write_data = 32'h1111_2222;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("midrst_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("midrst_read_data", read_data, 32'd0);
      chk("midrst_addr", {14'd0, sram_addr}, 32'd0);
      rst = 1'b0;
      // Low phase finished; the high phase had one strobed edge before reset took effect.
      ref_mem[h]     = 16'h2222;
      ref_mem[h + 1] = 16'h1111;
      do_access(1'b1, 1'b0, 32'd1036, 32'd0, {ref_mem[h + 1], ref_mem[h]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
